// File: rtl/mem_seq_pkg.sv
// Shared types and sizing helpers for the memory access sequencer of the
// multicycle MIPS core.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // Wait counter width: the largest reload value is max(latency)-1; keep at
    // least one bit so single-cycle latencies still elaborate.
    function automatic int cnt_width(input int rd_lat, input int wr_lat);
        int m;
        m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; counts the remaining wait states of
// the memory transaction currently in flight.
module mem_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load has priority; decrement is only requested while non-zero, so the
    // counter cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// Arbitrates instruction-fetch and data requests onto the single shared memory,
// holding address select / write strobe for the wait states and pulsing loads.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       data_we,
    output logic       IorD,
    output logic       wr,
    output logic       IRWrite,
    output logic       MDR_load,
    output logic       fetch_done,
    output logic       data_done,
    output logic       busy,
    output logic [1:0] StateOut
);

    localparam int CNT_W = cnt_width(READ_LATENCY, WRITE_LATENCY);
    localparam logic [CNT_W-1:0] RD_RELOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_RELOAD = CNT_W'(WRITE_LATENCY - 1);

    // Handshake: fetch_req/data_req are levels sampled only in S_IDLE; a grant
    // is final, and the matching *_done pulse marks the last busy cycle. The
    // requester must drop its request in the cycle after done, otherwise the
    // next S_IDLE cycle grants it again.

    state_e           state_q;
    state_e           state_d;
    owner_e           owner_q;
    owner_e           owner_d;
    state_e           state_out_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;

    mem_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Data access wins over fetch; fetch stays pending until idle.
                if (data_req) begin
                    owner_d  = OWN_DATA;
                    cnt_load = 1'b1;
                    if (data_we) begin
                        state_d      = S_WRITE;
                        cnt_load_val = WR_RELOAD;
                    end else begin
                        state_d      = S_READ;
                        cnt_load_val = RD_RELOAD;
                    end
                end else if (fetch_req) begin
                    owner_d      = OWN_FETCH;
                    state_d      = S_READ;
                    cnt_load     = 1'b1;
                    cnt_load_val = RD_RELOAD;
                end
            end
            S_READ, S_WRITE: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_FETCH;
            state_out_q <= S_IDLE;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            state_out_q <= state_q;
        end
    end

    // Every output is decoded from registers only, so no input reaches an
    // output combinationally.
    logic last_cycle;
    assign last_cycle = cnt_zero && (state_q != S_IDLE);

    assign busy       = (state_q != S_IDLE);
    assign IorD       = busy && (owner_q == OWN_DATA);
    assign wr         = (state_q == S_WRITE);
    assign IRWrite    = (state_q == S_READ) && cnt_zero && (owner_q == OWN_FETCH);
    assign fetch_done = IRWrite;
    assign MDR_load   = (state_q == S_READ) && cnt_zero && (owner_q == OWN_DATA);
    assign data_done  = last_cycle && (owner_q == OWN_DATA);
    assign StateOut   = state_out_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer with READ_LATENCY=2, WRITE_LATENCY=3.
module tb_mem_access_sequencer;

  localparam int RL = 2;
  localparam int WL = 3;
  localparam int W  = 25;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       fetch_req = 1'b0;
  logic       data_req = 1'b0;
  logic       data_we = 1'b0;
  logic       IorD, wr, IRWrite, MDR_load, fetch_done, data_done, busy;
  logic [1:0] StateOut;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k;

  // Entry: {cycle[15:0], busy, IorD, wr, IRWrite, MDR_load, fetch_done, data_done, StateOut[1:0]}
  logic [W-1:0] exp_q[$];

  mem_access_sequencer #(
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .data_we    (data_we),
    .IorD       (IorD),
    .wr         (wr),
    .IRWrite    (IRWrite),
    .MDR_load   (MDR_load),
    .fetch_done (fetch_done),
    .data_done  (data_done),
    .busy       (busy),
    .StateOut   (StateOut)
  );

  // clock / cycle counter
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // expected busy-cycle vectors of one transaction granted at the edge after cycle start
  task automatic push_txn(input int start, input bit is_data, input bit we, input int ncyc);
    int lat;
    logic [8:0] v;
    logic [15:0] c;
    lat = we ? WL : RL;
    for (int j = 1; j <= ncyc; j++) begin
      v = {1'b1, is_data, we,
           (!is_data && j == lat),
           (is_data && !we && j == lat),
           (!is_data && j == lat),
           (is_data && j == lat),
           (j == 1) ? 2'd0 : (we ? 2'd2 : 2'd1)};
      c = 16'(start + j);
      exp_q.push_back({c, v});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, IorD, wr, IRWrite, MDR_load, fetch_done, data_done, StateOut} != 10'd0) begin
      errors++;
      $display("FAIL %s: outputs busy=%b IorD=%b wr=%b IRWrite=%b MDR_load=%b fetch_done=%b data_done=%b StateOut=%0d, required all 0",
               name, busy, IorD, wr, IRWrite, MDR_load, fetch_done, data_done, StateOut);
    end
  endtask

  // monitor: compare every busy cycle against the scoreboard, idle cycles against zero
  always @(negedge Clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (Reset_n) begin
      act = {16'(cyc), busy, IorD, wr, IRWrite, MDR_load, fetch_done, data_done, StateOut};
      checks++;
      if (busy) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy: cycle %0d vec %b, no transaction expected", cyc, act[8:0]);
        end else begin
          exp = exp_q.pop_front();
          if (act != exp) begin
            errors++;
            $display("FAIL busy_cycle: got cycle %0d vec %b, required cycle %0d vec %b (busy,IorD,wr,IRWrite,MDR_load,fetch_done,data_done,StateOut)",
                     act[24:9], act[8:0], exp[24:9], exp[8:0]);
          end
        end
      end else if ({IorD, wr, IRWrite, MDR_load, fetch_done, data_done} != 6'd0) begin
        errors++;
        $display("FAIL idle_outputs: cycle %0d IorD=%b wr=%b IRWrite=%b MDR_load=%b fetch_done=%b data_done=%b, required 0",
                 cyc, IorD, wr, IRWrite, MDR_load, fetch_done, data_done);
      end
    end
  end

  initial begin
    // reset state
    @(posedge Clk);
    #1;
    check_all_zero("reset_state");
    @(negedge Clk);
    Reset_n = 1'b1;
    step(1);

    // instruction fetch
    k = cyc; fetch_req = 1'b1; push_txn(k, 1'b0, 1'b0, RL);
    step(1); fetch_req = 1'b0;
    step(RL + 1);

    // data load
    k = cyc; data_req = 1'b1; data_we = 1'b0; push_txn(k, 1'b1, 1'b0, RL);
    step(1); data_req = 1'b0;
    step(RL + 1);

    // data store
    k = cyc; data_req = 1'b1; data_we = 1'b1; push_txn(k, 1'b1, 1'b1, WL);
    step(1); data_req = 1'b0; data_we = 1'b0;
    step(WL + 1);

    // simultaneous requests: data first, fetch after one idle cycle
    k = cyc; fetch_req = 1'b1; data_req = 1'b1;
    push_txn(k, 1'b1, 1'b0, RL);
    push_txn(k + RL + 1, 1'b0, 1'b0, RL);
    step(1); data_req = 1'b0;
    step(RL + 1); fetch_req = 1'b0;
    step(RL + 1);

    // reset during READ with cnt=1: aborts without a done pulse
    k = cyc; fetch_req = 1'b1; push_txn(k, 1'b0, 1'b0, 1);
    step(1); fetch_req = 1'b0;
    @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_abort");
    @(posedge Clk);
    #1;
    check_all_zero("reset_held");
    Reset_n = 1'b1;
    step(1);
    k = cyc; fetch_req = 1'b1; push_txn(k, 1'b0, 1'b0, RL);
    step(1); fetch_req = 1'b0;
    step(RL + 1);

    // request dropped and data_we flipped mid-READ: load completes as granted
    k = cyc; data_req = 1'b1; data_we = 1'b0; push_txn(k, 1'b1, 1'b0, RL);
    step(1); data_req = 1'b0; data_we = 1'b1;
    step(1); data_we = 1'b0;
    step(RL);

    // request held through done: back-to-back loads with one idle cycle between
    k = cyc; data_req = 1'b1; data_we = 1'b0;
    push_txn(k, 1'b1, 1'b0, RL);
    push_txn(k + RL + 1, 1'b1, 1'b0, RL);
    step(RL + 2); data_req = 1'b0;
    step(RL + 2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected busy cycles never observed, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Sequences every access to the single shared instruction/data memory of the multicycle MIPS core. Accepts level requests from the main control FSM (instruction fetch) and from the load/store states (data read/write), arbitrates with fixed priority, holds the memory address select and write strobe for the programmed wait states, and pulses the IR/MDR load enables and a done flag on the last cycle. This replaces hard-coded memory delay states in the control FSM.

## Interface
- READ_LATENCY, 2: cycles memory needs for a read (≥1).
- WRITE_LATENCY, 1: cycles wr must be held for a write (≥1).
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  level request for instruction fetch at PC.
- data_req  in  1  level request for data access at ALUOut.
- data_we  in  1  with data_req: 1 = store, 0 = load; sampled at grant.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- wr  out  1  memory write strobe.
- IRWrite  out  1  instruction register load enable.
- MDR_load  out  1  memory data register load enable.
- fetch_done  out  1  one-cycle pulse, fetch complete.
- data_done  out  1  one-cycle pulse, data access complete.
- busy  out  1  transaction in progress.
- StateOut  out  2  current state encoding, for debug.

## Operation
- States: IDLE, READ, WRITE.
- Registered: state, owner (FETCH/DATA), wait counter cnt.
- IDLE: at clock edge, if data_req → owner=DATA; if data_we → WRITE, cnt=WRITE_LATENCY-1; else READ, cnt=READ_LATENCY-1. Else if fetch_req → owner=FETCH, READ, cnt=READ_LATENCY-1. Else stay.
- Simultaneous fetch_req and data_req: data wins; fetch stays pending, served next IDLE.
- READ/WRITE: cnt decrements each cycle; when cnt==0, next state IDLE.
- Outputs, all decoded from registered state (no combinational path from inputs):
  - busy = state≠IDLE.
  - IorD = busy & owner==DATA.
  - wr = state==WRITE.
  - IRWrite = READ & cnt==0 & owner==FETCH; fetch_done identical.
  - MDR_load = READ & cnt==0 & owner==DATA.
  - data_done = (READ|WRITE) & cnt==0 & owner==DATA.
- Requests and data_we are ignored while busy; a granted transaction always completes even if its request drops.
- Requester must deassert in the cycle after its done pulse; a request still high in IDLE starts a new transaction.
- Counter width $clog2(max(READ_LATENCY,WRITE_LATENCY)); no wrap possible since it reloads only in IDLE.

## Timing
- Reset (async assert, any state, including mid-transaction): state=IDLE, owner=FETCH, cnt=0; all outputs 0 immediately; StateOut=IDLE. Aborted transaction produces no done pulse.
- Read latency: request high in IDLE cycle N → busy from N+1, IRWrite/MDR_load and done in cycle N+READ_LATENCY, IDLE in N+READ_LATENCY+1.
- Write: wr high cycles N+1..N+WRITE_LATENCY; data_done on the last.
- Throughput: one transaction per LATENCY+1 cycles (one IDLE cycle between transactions).
- StateOut registered copy of state, one cycle behind.

## Structure
- mem_seq_pkg: state enum (IDLE=0, READ=1, WRITE=2), owner enum, LATENCY width function.
- One sub-module: mem_wait_counter (loadable down-counter with zero flag, parameterised width).
- Top module holds the FSM, arbitration and output decode.

## Test plan
- Reset then fetch_req=1 (L=2): IRWrite and fetch_done high exactly cycle 2 after request, IorD=0, wr=0 throughout.
- data_req=1, data_we=0: IorD=1 cycles 1–2, MDR_load and data_done cycle 2, IRWrite never.
- data_req=1, data_we=1, WRITE_LATENCY=3: wr=1, IorD=1 cycles 1–3, data_done only cycle 3.
- fetch_req and data_req high same cycle: data read completes first, then IDLE one cycle, then fetch completes 3 cycles later.
- Reset_n low during READ cnt=1: outputs 0 asynchronously, no done pulse, restart fetch after release completes normally.
- data_req toggled mid-READ and data_we changed: transaction completes as originally granted.
